// File: rtl/apb_rr_master_arbiter_if.sv
// Requester-side request/response ports and the APB bus of the round-robin APB master.
// The master modport is the controller's view; the slave modport is the requester/peripheral side.
interface apb_rr_master_arbiter_if #(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_write;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_wdata;
   logic [N_REQ-1:0]        req_ack;
   logic [N_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]       rsp_rdata;
   logic                    rsp_err;
   logic [ADDR_W-1:0]       paddr;
   logic [DATA_W-1:0]       pwdata;
   logic                    pwrite;
   logic                    psel;
   logic                    penable;
   logic                    pready;
   logic [DATA_W-1:0]       prdata;
   logic                    pslverr;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, pready, prdata, pslverr,
      output req_ack, rsp_valid, rsp_rdata, rsp_err, paddr, pwdata, pwrite, psel, penable
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, pready, prdata, pslverr,
      input  req_ack, rsp_valid, rsp_rdata, rsp_err, paddr, pwdata, pwrite, psel, penable
   );
endinterface

// File: rtl/apb_rr_master_arbiter.sv
// APB master shared by N_REQ requesters: round-robin grant, SETUP/ACCESS sequencing,
// wait states, pslverr forwarding and an ACCESS-phase timeout.
module apb_rr_master_arbiter #(
   parameter int N_REQ   = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                    pclk,
   input  logic                    preset,
   apb_rr_master_arbiter_if.master bus
);
   localparam int PTR_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t             state;
   state_t             next_state;
   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   grant;
   logic [CNT_W-1:0]   cnt;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic               write_q;
   logic               done;
   logic               timed_out;

   assign bus.paddr  = addr_q;
   assign bus.pwdata = wdata_q;
   assign bus.pwrite = write_q;

   // Search starts just after the last winner so the previous grantee ends up lowest priority.
   always_comb begin : grant_search
      int   cand;
      logic found;
      grant = ptr;
      found = 1'b0;
      cand  = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = (int'(ptr) + k) % N_REQ;
         if (!found && bus.req_valid[cand]) begin
            grant = PTR_W'(cand);
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state  = state;
      bus.req_ack = '0;
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      done        = 1'b0;
      timed_out   = 1'b0;
      case (state)
         IDLE: begin
            if (|bus.req_valid) begin
               bus.req_ack[grant] = 1'b1;
               next_state         = SETUP;
            end
         end
         SETUP: begin
            bus.psel   = 1'b1;
            next_state = ACCESS;
         end
         ACCESS: begin
            bus.psel    = 1'b1;
            bus.penable = 1'b1;
            if (bus.pready) begin
               done       = 1'b1;
               next_state = IDLE;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               timed_out  = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // ptr doubles as the index of the requester owning the transfer in flight.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         ptr           <= PTR_W'(N_REQ - 1);
         cnt           <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         write_q       <= 1'b0;
         bus.rsp_valid <= '0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         bus.rsp_valid <= '0;
         if (state == IDLE && |bus.req_valid) begin
            ptr     <= grant;
            addr_q  <= bus.req_addr[int'(grant)*ADDR_W +: ADDR_W];
            wdata_q <= bus.req_wdata[int'(grant)*DATA_W +: DATA_W];
            write_q <= bus.req_write[grant];
         end
         if (state == ACCESS && !done && !timed_out) cnt <= cnt + 1'b1;
         else                                        cnt <= '0;
         if (done || timed_out) begin
            bus.rsp_valid[ptr] <= 1'b1;
            bus.rsp_err        <= timed_out | bus.pslverr;
            bus.rsp_rdata      <= (done && !write_q && !bus.pslverr) ? bus.prdata : '0;
         end
      end
   end
endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Directed bench for apb_rr_master_arbiter: a small APB register slave, a response
// scoreboard filled at ack time and a monitor that checks every rsp_valid pulse.
module tb_apb_rr_master_arbiter;
   logic pclk;
   logic preset;

   apb_rr_master_arbiter_if #(.N_REQ(2), .ADDR_W(32), .DATA_W(32)) bus ();

   apb_rr_master_arbiter #(.N_REQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .pclk  (pclk),
      .preset(preset),
      .bus   (bus.master)
   );

   typedef struct {
      int          idx;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   int          wait_cfg = 0;
   bit          hang     = 1'b0;
   int          wait_cnt = 0;
   logic [31:0] mem [0:15];

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   // Register slave: answers after wait_cfg stalled cycles, never when hang is set, errors on 0x10.
   assign bus.pready  = bus.psel && bus.penable && !hang && (wait_cnt >= wait_cfg);
   assign bus.pslverr = bus.pready && (bus.paddr == 32'h10);
   assign bus.prdata  = mem[bus.paddr[5:2]];

   always @(posedge pclk) begin
      if (bus.psel && bus.penable && bus.pready && bus.pwrite && !bus.pslverr)
         mem[bus.paddr[5:2]] <= bus.pwdata;
      if (bus.psel && bus.penable && !bus.pready) wait_cnt <= wait_cnt + 1;
      else                                        wait_cnt <= 0;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic pushExp(input int idx, input logic err, input logic [31:0] rdata);
      exp_t e;
      e.idx   = idx;
      e.err   = err;
      e.rdata = rdata;
      sb.push_back(e);
   endtask

   always @(negedge pclk) begin
      if (!preset && bus.rsp_valid != 2'b00) begin
         if (sb.size() == 0) begin
            checkOutput("rsp_unexpected", 64'(bus.rsp_valid), 64'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(2'b01 << e.idx));
            checkOutput("rsp_err",   64'(bus.rsp_err),   64'(e.err));
            checkOutput("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
         end
      end
   end

   task automatic drainResponses();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge pclk);
         n++;
      end
      if (sb.size() != 0) checkOutput("drain_timeout", 64'(sb.size()), 64'h0);
      @(posedge pclk); #1;
   endtask

   // One request from requester idx; also checks APB field stability and ACCESS length.
   task automatic applyStimulus(input int idx, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic exp_err,
                                input logic [31:0] exp_rdata, input int exp_pen);
      bit got_ack;
      int pen;
      got_ack = 1'b0;
      pen     = 0;
      bus.req_write[idx]          = wr;
      bus.req_addr[idx*32 +: 32]  = addr;
      bus.req_wdata[idx*32 +: 32] = wdata;
      bus.req_valid[idx]          = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge pclk);
         if (bus.req_ack[idx]) begin
            got_ack = 1'b1;
            break;
         end
         @(posedge pclk); #1;
      end
      if (!got_ack) begin
         checkOutput("ack_timeout", 64'(bus.req_ack), 64'(2'b01 << idx));
         bus.req_valid[idx] = 1'b0;
         return;
      end
      pushExp(idx, exp_err, exp_rdata);
      @(posedge pclk); #1;
      bus.req_valid[idx] = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge pclk);
         if (bus.rsp_valid != 2'b00) break;
         if (bus.penable) begin
            pen++;
            checkOutput("hold_paddr",  64'(bus.paddr),  64'(addr));
            checkOutput("hold_pwdata", 64'(bus.pwdata), 64'(wdata));
            checkOutput("hold_pwrite", 64'(bus.pwrite), 64'(wr));
         end
      end
      checkOutput("rsp_target",     64'(bus.rsp_valid), 64'(2'b01 << idx));
      checkOutput("penable_cycles", 64'(pen),           64'(exp_pen));
      drainResponses();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [1:0] rr_order [4];
      int n;
      int cyc;
      int last;
      rr_order[0] = 2'b01;
      rr_order[1] = 2'b10;
      rr_order[2] = 2'b01;
      rr_order[3] = 2'b10;

      preset        = 1'b1;
      bus.req_valid = '0;
      bus.req_write = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;

      // Reset values
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      checkOutput("rst_psel",      64'(bus.psel),      64'h0);
      checkOutput("rst_penable",   64'(bus.penable),   64'h0);
      checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
      checkOutput("rst_rsp_err",   64'(bus.rsp_err),   64'h0);
      checkOutput("rst_paddr",     64'(bus.paddr),     64'h0);
      checkOutput("rst_req_ack",   64'(bus.req_ack),   64'h0);
      @(posedge pclk); #1;
      preset = 1'b0;

      // Reset in the middle of an ACCESS that the slave never completes
      hang          = 1'b1;
      bus.req_addr  = {32'h0, 32'h4};
      bus.req_valid = 2'b01;
      @(negedge pclk);
      checkOutput("abort_ack", 64'(bus.req_ack), 64'h1);
      @(posedge pclk); #1;
      bus.req_valid = 2'b00;
      repeat (2) begin
         @(posedge pclk); #1;
      end
      @(negedge pclk);
      checkOutput("abort_penable", 64'(bus.penable), 64'h1);
      #1 preset = 1'b1;
      #1;
      checkOutput("abort_psel_drop",    64'(bus.psel),      64'h0);
      checkOutput("abort_penable_drop", 64'(bus.penable),   64'h0);
      checkOutput("abort_no_rsp",       64'(bus.rsp_valid), 64'h0);
      repeat (2) @(posedge pclk);
      hang = 1'b0;
      #1 preset = 1'b0;

      // Both requesters valid after reset: requester 0 first; requester 1 withdraws
      bus.req_write = 2'b01;
      bus.req_addr  = {32'h8, 32'h0};
      bus.req_wdata = {32'h0, 32'hDEADBEEF};
      bus.req_valid = 2'b11;
      @(negedge pclk);
      checkOutput("first_grant", 64'(bus.req_ack), 64'h1);
      pushExp(0, 1'b0, 32'h0);
      @(posedge pclk); #1;
      bus.req_valid = 2'b00;
      @(negedge pclk);
      checkOutput("c1_psel",    64'(bus.psel),    64'h1);
      checkOutput("c1_penable", 64'(bus.penable), 64'h0);
      checkOutput("c1_paddr",   64'(bus.paddr),   64'h0);
      checkOutput("c1_pwdata",  64'(bus.pwdata),  64'hDEADBEEF);
      checkOutput("c1_pwrite",  64'(bus.pwrite),  64'h1);
      @(posedge pclk); #1;
      @(negedge pclk);
      checkOutput("c2_psel",    64'(bus.psel),    64'h1);
      checkOutput("c2_penable", 64'(bus.penable), 64'h1);
      @(posedge pclk); #1;
      @(negedge pclk);
      checkOutput("c3_rsp_valid", 64'(bus.rsp_valid), 64'h1);
      checkOutput("c3_psel",      64'(bus.psel),      64'h0);
      drainResponses();

      applyStimulus(0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1);
      applyStimulus(1, 1'b1, 32'h8, 32'h22222222, 1'b0, 32'h0, 1);

      // Round robin with both held valid; requester 1 was served last
      bus.req_write = 2'b01;
      bus.req_addr  = {32'h8, 32'h4};
      bus.req_wdata = {32'h0, 32'hA0A0A0A0};
      bus.req_valid = 2'b11;
      n    = 0;
      cyc  = 0;
      last = 0;
      while (n < 4 && cyc < 40) begin
         @(negedge pclk);
         cyc++;
         if (bus.req_ack != 2'b00) begin
            checkOutput("rr_grant", 64'(bus.req_ack), 64'(rr_order[n]));
            if (n > 0) checkOutput("rr_gap", 64'(cyc - last), 64'h3);
            last = cyc;
            if (rr_order[n] == 2'b01) pushExp(0, 1'b0, 32'h0);
            else                      pushExp(1, 1'b0, 32'h22222222);
            n++;
         end
         @(posedge pclk); #1;
      end
      bus.req_valid = 2'b00;
      if (n < 4) checkOutput("rr_timeout", 64'(n), 64'h4);
      drainResponses();

      // Wait states, then readback
      wait_cfg = 3;
      applyStimulus(1, 1'b1, 32'hC, 32'h5A5A5A5A, 1'b0, 32'h0, 4);
      wait_cfg = 0;
      applyStimulus(0, 1'b0, 32'hC, 32'h0, 1'b0, 32'h5A5A5A5A, 1);
      applyStimulus(0, 1'b0, 32'h4, 32'h0, 1'b0, 32'hA0A0A0A0, 1);

      // Slave error
      applyStimulus(1, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1);

      // Timeout, then a normal transfer
      hang = 1'b1;
      applyStimulus(0, 1'b0, 32'h4, 32'h0, 1'b1, 32'h0, 16);
      hang = 1'b0;
      applyStimulus(1, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1);

      repeat (5) @(posedge pclk);
      checkOutput("sb_empty", 64'(sb.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
